// File: rtl/router_pkg.sv
// Shared types and flit layout helpers for the mesh router.
// Optional feature macro used by the input port: ROUTER_PORT_CNT_EN.
package router_pkg;

    typedef enum logic [1:0] {
        RT_MESH  = 2'd0,
        RT_TORUS = 2'd1
    } router_type;

    typedef enum logic [1:0] {
        ROUTE_SELF = 2'd0,
        ROUTE_NS   = 2'd1,
        ROUTE_WE   = 2'd2,
        ROUTE_DIAG = 2'd3
    } route_e;

    localparam int NUM_OUTPUTS      = 4;
    localparam int FLIT_PAYLOAD_LSB = 0;

    // Flit layout is {dst_y, dst_x, payload}; offsets depend on the field widths
    function automatic int flitXLsb(input int dataW);
        return dataW;
    endfunction

    function automatic int flitYLsb(input int dataW, input int xW);
        return dataW + xW;
    endfunction

endpackage

// File: rtl/router_route_calc.sv
// Route computation: compares a flit destination against this router's coordinates.
module router_route_calc
    import router_pkg::*;
#(
    parameter int selfx = 2,
    parameter int selfy = 2,
    parameter int maxx  = 2,
    parameter int maxy  = 2
) (
    input  logic [maxx-1:0] dst_x,
    input  logic [maxy-1:0] dst_y,
    output route_e          route_o
);

    localparam logic [maxx-1:0] SELF_X = maxx'(selfx);
    localparam logic [maxy-1:0] SELF_Y = maxy'(selfy);

    logic w_xEq;
    logic w_yEq;

    assign w_xEq = (dst_x == SELF_X);
    assign w_yEq = (dst_y == SELF_Y);

    always_comb begin
        route_o = ROUTE_DIAG;
        if (w_xEq && w_yEq) begin
            route_o = ROUTE_SELF;
        end else if (w_xEq) begin
            route_o = ROUTE_NS;
        end else if (w_yEq) begin
            route_o = ROUTE_WE;
        end
    end

endmodule

// File: rtl/router_input_port.sv
// Mesh router input port: flit FIFO with head-of-line route steering to four outputs.
// Optional popped-flit counter output fwd_cnt_o when ROUTER_PORT_CNT_EN is defined.
module router_input_port
    import router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int maxx   = 2,
    parameter int maxy   = 2,
    parameter int selfx  = 2,
    parameter int selfy  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [maxy+maxx+DATA_W-1:0]   in_flit_i,
    output logic [3:0]                    out_valid_o,
    input  logic [3:0]                    out_ready_i,
    output logic [maxy+maxx+DATA_W-1:0]   out_flit_o,
    output logic [$clog2(DEPTH):0]        count_o
`ifdef ROUTER_PORT_CNT_EN
    ,
    output logic [15:0]                   fwd_cnt_o
`endif
);

    localparam int FLIT_W = maxy + maxx + DATA_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int X_LSB  = flitXLsb(DATA_W);
    localparam int Y_LSB  = flitYLsb(DATA_W, maxx);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;

    logic [FLIT_W-1:0] w_head;
    route_e            w_route;
    logic              w_push;
    logic              w_pop;
    logic              w_notEmpty;

    assign w_head     = r_mem[r_rdPtr];
    assign w_notEmpty = (r_count != '0);

    router_route_calc #(
        .selfx (selfx),
        .selfy (selfy),
        .maxx  (maxx),
        .maxy  (maxy)
    ) u_routeCalc (
        .dst_x   (w_head[X_LSB +: maxx]),
        .dst_y   (w_head[Y_LSB +: maxy]),
        .route_o (w_route)
    );

    // Ready depends only on registered occupancy so upstream sees no comb path
    assign in_ready_o  = (r_count != FULL_CNT);
    assign out_valid_o = w_notEmpty ? (4'b0001 << w_route) : 4'b0000;
    assign out_flit_o  = w_head;
    assign count_o     = r_count;

    assign w_push = in_valid_i && in_ready_o;
    assign w_pop  = |(out_valid_o & out_ready_i);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_flit_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ROUTER_PORT_CNT_EN
    logic [15:0] r_fwdCnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fwdCnt <= '0;
        end else if (w_pop && (r_fwdCnt != 16'hFFFF)) begin
            r_fwdCnt <= r_fwdCnt + 16'd1;
        end
    end

    assign fwd_cnt_o = r_fwdCnt;
`endif

endmodule

// File: tb/tb_router_input_port.sv
// Directed scoreboard bench for router_input_port (selfx=2, selfy=2, default sizes).
// Exercises fwd_cnt_o as well when ROUTER_PORT_CNT_EN is defined.
module tb_router_input_port;

    localparam int DATA_W = 8;
    localparam int FLIT_W = 12;
    localparam int DEPTH  = 4;

    logic              clk_i;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [FLIT_W-1:0] in_flit_i;
    logic [3:0]        out_valid_o;
    logic [3:0]        out_ready_i;
    logic [FLIT_W-1:0] out_flit_o;
    logic [2:0]        count_o;
`ifdef ROUTER_PORT_CNT_EN
    logic [15:0]       fwd_cnt_o;
    logic [15:0]       expFwd;
`endif

    int checks;
    int errors;
    logic [FLIT_W-1:0] sb[$];

    router_input_port #(
        .DATA_W (DATA_W),
        .maxx   (2),
        .maxy   (2),
        .selfx  (2),
        .selfy  (2),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_flit_i   (in_flit_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_flit_o  (out_flit_o),
        .count_o     (count_o)
`ifdef ROUTER_PORT_CNT_EN
        ,
        .fwd_cnt_o   (fwd_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [FLIT_W-1:0] mkFlit(input int x, input int y, input int p);
        logic [1:0] fx;
        logic [1:0] fy;
        logic [7:0] fp;
        fx = 2'(x);
        fy = 2'(y);
        fp = 8'(p);
        return {fy, fx, fp};
    endfunction

    // Independent reference for the route rules with this router at (2,2)
    function automatic logic [1:0] expRoute(input logic [FLIT_W-1:0] f);
        logic xEq;
        logic yEq;
        xEq = (f[9:8] == 2'd2);
        yEq = (f[11:10] == 2'd2);
        if (xEq && yEq) return 2'd0;
        if (xEq)        return 2'd1;
        if (yEq)        return 2'd2;
        return 2'd3;
    endfunction

    task automatic checkBit(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called away from the rising edge: compare outputs, then advance the model
    task automatic checkOutput(input string tag);
        logic [3:0] expValid;
        logic       doPop;
        logic       doPush;
        checkBit({tag, ".count"}, 32'(count_o), 32'(sb.size()));
        checkBit({tag, ".inReady"}, 32'(in_ready_o), 32'(sb.size() != DEPTH));
        expValid = 4'b0000;
        if (sb.size() > 0) begin
            expValid = 4'b0001 << expRoute(sb[0]);
            checkBit({tag, ".flit"}, 32'(out_flit_o), 32'(sb[0]));
        end
        checkBit({tag, ".outValid"}, 32'(out_valid_o), 32'(expValid));
`ifdef ROUTER_PORT_CNT_EN
        checkBit({tag, ".fwdCnt"}, 32'(fwd_cnt_o), 32'(expFwd));
`endif
        doPop  = (sb.size() > 0) && ((expValid & out_ready_i) != 4'b0000);
        doPush = in_valid_i && (sb.size() != DEPTH);
        if (doPop) begin
            void'(sb.pop_front());
`ifdef ROUTER_PORT_CNT_EN
            if (expFwd != 16'hFFFF) expFwd = expFwd + 16'd1;
`endif
        end
        if (doPush) sb.push_back(in_flit_i);
    endtask

    task automatic applyStimulus(input logic v, input logic [FLIT_W-1:0] f,
                                 input logic [3:0] rdy, input string tag);
        in_valid_i  = v;
        in_flit_i   = f;
        out_ready_i = rdy;
        @(negedge clk_i);
        checkOutput(tag);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_flit_i   = '0;
        out_ready_i = 4'b0000;
`ifdef ROUTER_PORT_CNT_EN
        expFwd      = '0;
`endif
        #12;
        checkOutput("reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Four routes back to back with every output ready
        applyStimulus(1'b1, mkFlit(2, 2, 8'h11), 4'b1111, "route.self");
        applyStimulus(1'b1, mkFlit(2, 1, 8'h22), 4'b1111, "route.ns");
        applyStimulus(1'b1, mkFlit(1, 2, 8'h33), 4'b1111, "route.we");
        applyStimulus(1'b1, mkFlit(0, 0, 8'h44), 4'b1111, "route.diag");
        applyStimulus(1'b0, '0, 4'b1111, "route.drain");
        applyStimulus(1'b0, '0, 4'b1111, "route.idle");

        // Fill to capacity with nothing ready; fifth attempt must bounce
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, mkFlit(2, 0, 8'hA0 + i), 4'b0000, "full.push");
        end
        applyStimulus(1'b0, '0, 4'b0000, "full.hold");

        // Pop at full while offering a flit, then concurrent push and pop
        applyStimulus(1'b1, mkFlit(2, 0, 8'hB0), 4'b0010, "full.popOnly");
        applyStimulus(1'b1, mkFlit(2, 0, 8'hB1), 4'b0010, "mid.pushPop");
        applyStimulus(1'b0, '0, 4'b0000, "mid.count");

        // NS head blocked while every other output is ready
        applyStimulus(1'b0, '0, 4'b1101, "hol.block0");
        applyStimulus(1'b0, '0, 4'b1101, "hol.block1");
        applyStimulus(1'b0, '0, 4'b1101, "hol.block2");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 4'b1111, "hol.drain");
        end

        // Streaming through several pointer wraps
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, mkFlit($urandom_range(0, 3), $urandom_range(0, 3), 8'hC0 + i),
                          4'b1111, "wrap.stream");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 4'b1111, "wrap.drain");
        end

        // Asynchronous reset mid-transfer with three flits buffered
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mkFlit(1, 1, 8'hD0 + i), 4'b0000, "rst.fill");
        end
        in_valid_i  = 1'b1;
        in_flit_i   = mkFlit(1, 1, 8'hDF);
        out_ready_i = 4'b1111;
        #2;
        rst_i = 1'b1;
        #1;
        sb.delete();
`ifdef ROUTER_PORT_CNT_EN
        expFwd = '0;
`endif
        checkBit("rst.outValid", 32'(out_valid_o), 32'h0);
        checkBit("rst.count", 32'(count_o), 32'h0);
        checkBit("rst.inReady", 32'(in_ready_o), 32'h1);
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        applyStimulus(1'b0, '0, 4'b1111, "rst.after");

`ifdef ROUTER_PORT_CNT_EN
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, mkFlit(3, 3, 8'hE0 + i), 4'b1111, "cnt.seven");
        end
        applyStimulus(1'b0, '0, 4'b1111, "cnt.sevenPop");
        applyStimulus(1'b0, '0, 4'b1111, "cnt.sevenChk");
        checkBit("cnt.seven", 32'(fwd_cnt_o), 32'd7);
        force dut.r_fwdCnt = 16'hFFFE;
        #1;
        release dut.r_fwdCnt;
        expFwd = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mkFlit(3, 3, 8'hF0 + i), 4'b1111, "cnt.sat");
        end
        applyStimulus(1'b0, '0, 4'b1111, "cnt.satPop");
        applyStimulus(1'b0, '0, 4'b1111, "cnt.satChk");
        checkBit("cnt.sat", 32'(fwd_cnt_o), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
